// File: rtl/sw_debounce.sv
// Switch debouncer: two-flop synchronizer followed by a per-bit stable-count filter.
// Define SW_EDGE_EN to build the pressed/released one-cycle edge pulses.
module sw_debounce #(
    parameter int unsigned N         = 8,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] sw_out,
    output logic [N-1:0] pressed,
    output logic [N-1:0] released
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [N-1:0]         s0;
    logic [N-1:0]         s1;
    logic [N-1:0]         out_nxt;
    logic [N-1:0][CW-1:0] cnt;
    logic [N-1:0][CW-1:0] cnt_nxt;

    // Metastability guard for the asynchronous board inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            s0 <= sw_in;
            s1 <= s0;
        end
    end

    // A bit is accepted only after DB_CYCLES consecutive synchronized samples
    // disagree with the current output; any agreement restarts the count.
    always_comb begin
        cnt_nxt = cnt;
        out_nxt = sw_out;
        for (int i = 0; i < int'(N); i++) begin
            if (s1[i] == sw_out[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt_nxt[i] = '0;
                out_nxt[i] = s1[i];
            end else begin
                cnt_nxt[i] = cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            sw_out <= '0;
        end else begin
            cnt    <= cnt_nxt;
            sw_out <= out_nxt;
        end
    end

`ifdef SW_EDGE_EN
    // Pulses line up with the cycle in which sw_out first shows the new level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pressed  <= '0;
            released <= '0;
        end else begin
            pressed  <= out_nxt & ~sw_out;
            released <= ~out_nxt & sw_out;
        end
    end
`else
    assign pressed  = '0;
    assign released = '0;
`endif

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the switch bus width, equal to the CPU sw width.
REQ-002 The block SHALL have parameter DB_CYCLES, default 4, giving the stable-cycle count required to accept a change; legal range 1..65535.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 Port: sw_in  input  N  raw board switches, asynchronous to clk, may bounce.
REQ-006 Port: sw_out  output  N  synchronized, debounced switch levels; drives CPU sw.
REQ-007 Port: pressed  output  N  one-cycle pulse per bit on an accepted 0->1 transition.
REQ-008 Port: released  output  N  one-cycle pulse per bit on an accepted 1->0 transition.

Function
REQ-009 Each sw_in bit SHALL pass through a two-flop synchronizer (s0, s1) before any other logic uses it.
REQ-010 Each bit SHALL have an independent counter of width max(1, clog2(DB_CYCLES)), counting 0..DB_CYCLES-1.
REQ-011 If s1[i] equals sw_out[i], counter[i] SHALL load 0 on the next edge (any bounce back restarts the count).
REQ-012 If s1[i] differs from sw_out[i] and counter[i] < DB_CYCLES-1, counter[i] SHALL increment by 1.
REQ-013 If s1[i] differs from sw_out[i] and counter[i] == DB_CYCLES-1, sw_out[i] SHALL take s1[i] and counter[i] SHALL load 0 on that edge.
REQ-014 Latency: a sw_in change held stable SHALL appear on sw_out at the (2+DB_CYCLES)th rising edge after the change; with defaults, the 6th edge.
REQ-015 A change reverting to the old level within fewer than DB_CYCLES synchronized cycles SHALL never reach sw_out.
REQ-016 The counter SHALL never wrap: the DB_CYCLES-1 terminal state always resolves by REQ-011 or REQ-013.
REQ-017 pressed[i] SHALL be 1 for exactly the one cycle after sw_out[i] goes 0->1; released[i] likewise for 1->0; never both in one cycle.
REQ-018 Simultaneous accepted changes on several bits SHALL each produce their own pulses in the same cycle.
REQ-019 The DB_CYCLES=1 case SHALL accept a change one edge after it reaches s1, with no special-case handling.

Reset
REQ-020 While reset=0, s0, s1, sw_out, all counters, pressed and released SHALL be 0, regardless of clk.
REQ-021 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be produced by the reset itself.
REQ-022 After reset deasserts with sw_in nonzero, the resulting 0->1 acceptances SHALL follow REQ-014 and SHALL pulse pressed.

Configuration
REQ-023 Macro SW_EDGE_EN: when defined, pressed/released are generated per REQ-017 and REQ-018.
REQ-024 When SW_EDGE_EN is undefined, pressed and released SHALL be constant 0 with no edge-detect registers; sw_out behaviour is unchanged.

Verification (N=8, DB_CYCLES=4, SW_EDGE_EN defined unless stated)
REQ-025 Hold reset=0 with sw_in=8'hAD, then release it. Required: sw_out=8'h00 during reset and 8'hAD at the 6th edge; pressed=8'hAD for exactly one cycle.
REQ-026 From sw_out=8'hAD, drive sw_in=8'h2D and hold. Required: sw_out=8'h2D at the 6th edge; released=8'h80 for one cycle; pressed=0.
REQ-027 From sw_out=8'hAD, toggle bit7 0/1 every 2 cycles for 20 cycles, then return it to 1. Required: sw_out stays 8'hAD; no pulses.
REQ-028 Apply a 3-cycle glitch (DB_CYCLES-1) on bit0. Required: sw_out unchanged; no pulses.
REQ-029 Assert reset=0 for one cycle mid-count during a change to 8'hFF. Required: sw_out=8'h00 immediately; the change is re-accepted 6 edges after release with pressed=8'hFF.
REQ-030 Rerun REQ-025 and REQ-026 with SW_EDGE_EN undefined. Required: sw_out timing identical; pressed=released=8'h00 throughout.
